// File: rtl/aes_inv_sbox_seq.sv
// Sequential InvSubBytes engine for a 128-bit AES state.
// BPC bytes of the working register are substituted per RUN cycle, starting
// at byte 0 (the MSB byte), so a block takes NCYC = 16/BPC RUN cycles.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and data until
// that edge. in_ready is high only in IDLE, out_valid only in DONE, and
// out_data stays stable while out_valid is high and out_ready is low.
module aes_inv_sbox_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int NCYC = 16 / BPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  // Only divisors of 16 give a whole number of chunks per block.
  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_check
      $error("aes_inv_sbox_seq: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_work;
  logic [127:0]    w_work_run;
  logic [3:0]      w_base;
  logic [3:0]      w_pos;

  // Working register with the current chunk of BPC bytes substituted.
  always_comb begin
    w_work_run = r_work;
    w_base     = 4'(r_cnt) * 4'(BPC);
    w_pos      = w_base;
    for (int l = 0; l < BPC; l++) begin
      w_pos = w_base + 4'(l);
      w_work_run[{4'd15 - w_pos, 3'b000} +: 8] =
        inv_sbox(r_work[{4'd15 - w_pos, 3'b000} +: 8]);
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last chunk,
  // DONE -> IDLE on output handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)              w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT)     w_next = S_DONE;
      S_DONE:  if (out_ready)             w_next = S_IDLE;
      default:                            w_next = S_IDLE;
    endcase
  end

  // State, chunk counter and working register; reset discards any block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work <= in_data;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_work <= w_work_run;
          if (r_cnt == LAST_CNT) r_cnt <= '0;
          else                   r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_data  = r_work;
  assign dbg_state = r_state;

endmodule
